// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - PRBS7/15/23/31 generator, W bits per clock; checker compiled in with PRBS_CHECKER_EN
module prbs_gen_chk #(
  parameter int W     = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [30:0]      seed,
  output logic [W-1:0]     dout,
  output logic             valid
`ifdef PRBS_CHECKER_EN
  ,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef struct packed {
    logic [30:0]  st;
    logic [W-1:0] word;
  } adv_t;

  // Active-length mask: bits at and above L stay zero in every state register.
  function automatic logic [30:0] len_mask(input logic [1:0] m);
    case (m)
      2'd0:    len_mask = 31'h0000_007F;
      2'd1:    len_mask = 31'h0000_7FFF;
      2'd2:    len_mask = 31'h007F_FFFF;
      default: len_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  // Feedback bit: s[L-1] ^ s[T-1].
  function automatic logic fb_bit(input logic [30:0] st, input logic [1:0] m);
    case (m)
      2'd0:    fb_bit = st[6]  ^ st[5];
      2'd1:    fb_bit = st[14] ^ st[13];
      2'd2:    fb_bit = st[22] ^ st[17];
      default: fb_bit = st[30] ^ st[27];
    endcase
  endfunction

  // W single-bit steps unrolled; first emitted bit ends up in word[W-1].
  function automatic adv_t advance(input logic [30:0] st_in, input logic [1:0] m);
    adv_t r;
    logic b;
    r.st   = st_in;
    r.word = '0;
    for (int i = 0; i < W; i++) begin
      b      = fb_bit(r.st, m);
      r.st   = {r.st[29:0], b} & len_mask(m);
      r.word = (r.word << 1) | W'(b);
    end
    return r;
  endfunction

  logic [1:0]  mode_r;
  logic [30:0] s;
  logic [30:0] seed_l;
  adv_t        gen_nxt;

  assign gen_nxt = advance(s, mode_r);
  assign seed_l  = seed & len_mask(mode);

  // Generator: load (with zero-seed replacement) beats en; dout holds when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r <= 2'd0;
      s      <= 31'h0000_007F;
      dout   <= '0;
      valid  <= 1'b0;
    end else if (load) begin
      mode_r <= mode;
      s      <= (seed_l == 31'd0) ? len_mask(mode) : seed_l;
      valid  <= 1'b0;
    end else if (en) begin
      s      <= gen_nxt.st;
      dout   <= gen_nxt.word;
      valid  <= 1'b1;
    end else begin
      valid  <= 1'b0;
    end
  end

`ifdef PRBS_CHECKER_EN
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} chk_state_t;

  chk_state_t       state;
  logic [30:0]      c;
  logic [4:0]       hunt_cnt;
  logic [4:0]       hunt_need;
  int               hunt_len;
  logic [1:0]       run;
  adv_t             chk_pred;
  logic [W-1:0]     miss;
  logic [5:0]       miss_cnt;
  logic [30+W:0]    hunt_cat;
  logic [30:0]      hunt_nxt;
  logic [CNT_W+5:0] err_sum;
  logic [CNT_W-1:0] err_sat;

  assign chk_pred = advance(c, mode_r);
  assign miss     = chk_pred.word ^ din;
  assign hunt_cat = {c, din};
  assign hunt_nxt = hunt_cat[30:0] & len_mask(mode_r);
  assign err_sum  = (CNT_W+6)'(err_cnt) + (CNT_W+6)'(miss_cnt);
  assign err_sat  = (|err_sum[CNT_W+5:CNT_W]) ? '1 : err_sum[CNT_W-1:0];

  // Count of mismatched bits in the current word.
  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < W; i++) miss_cnt = miss_cnt + 6'(miss[i]);
  end

  // Words needed in HUNT to fill L bits of checker state: ceil(L/W).
  always_comb begin
    case (mode_r)
      2'd0:    hunt_len = 7;
      2'd1:    hunt_len = 15;
      2'd2:    hunt_len = 23;
      default: hunt_len = 31;
    endcase
    hunt_need = 5'((hunt_len + W - 1) / W);
  end

  // Checker FSM and saturating error counter; generator load restarts the hunt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      c        <= '1;
      hunt_cnt <= '0;
      run      <= '0;
      locked   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (err_clr)
        err_cnt <= '0;
      else if (din_valid && !load && state == LOCKED)
        err_cnt <= err_sat;

      if (load) begin
        state    <= HUNT;
        hunt_cnt <= '0;
        run      <= '0;
        locked   <= 1'b0;
      end else if (din_valid) begin
        case (state)
          HUNT: begin
            c <= hunt_nxt;
            if (hunt_cnt == hunt_need - 5'd1) begin
              state    <= SYNC;
              hunt_cnt <= '0;
              run      <= '0;
            end else begin
              hunt_cnt <= hunt_cnt + 5'd1;
            end
          end
          SYNC: begin
            c <= chk_pred.st;
            if (miss_cnt != 6'd0) begin
              state <= HUNT;
              run   <= '0;
            end else if (run == 2'd3) begin
              state  <= LOCKED;
              locked <= 1'b1;
              run    <= '0;
            end else begin
              run <= run + 2'd1;
            end
          end
          LOCKED: begin
            c <= chk_pred.st;
            if (miss_cnt != 6'd0) begin
              if (run == 2'd3) begin
                state  <= HUNT;
                locked <= 1'b0;
                run    <= '0;
              end else begin
                run <= run + 2'd1;
              end
            end else begin
              run <= '0;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - scoreboard bench for prbs_gen_chk; checker section active with PRBS_CHECKER_EN
module tb_prbs_gen_chk;

  logic        clk;
  logic        reset;
  logic        en1, load1, valid1;
  logic [1:0]  mode1;
  logic [30:0] seed1;
  logic [0:0]  dout1;
  logic        en8, load8, valid8;
  logic [1:0]  mode8;
  logic [30:0] seed8;
  logic [7:0]  dout8;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] w;
  } exp_t;

  exp_t        q1[$];
  exp_t        q8[$];
  logic        hist[$];
  logic [31:0] m1_st, m8_st;
  int          m1_mode, m8_mode;
  logic [7:0]  w1_last, w8_last;
  int          l_tab[4] = '{7, 15, 23, 31};
  int          t_tab[4] = '{6, 14, 18, 28};

`ifdef PRBS_CHECKER_EN
  logic        lk1, lk8;
  logic [15:0] ec1, ec8;
  logic        en4, load4, valid4, err_clr4, locked4;
  logic [1:0]  mode4;
  logic [30:0] seed4;
  logic [3:0]  dout4, din4, err_mask, err_cnt4;
  logic [3:0]  sat_masks[7] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0};
  int          words, exp_cnt;
  logic        got;
  assign din4 = dout4 ^ err_mask;
`endif

  prbs_gen_chk #(.W(1), .CNT_W(16)) u_gen1 (
    .clk(clk), .reset(reset), .en(en1), .load(load1), .mode(mode1), .seed(seed1),
    .dout(dout1), .valid(valid1)
`ifdef PRBS_CHECKER_EN
    , .din(dout1), .din_valid(valid1), .err_clr(1'b0), .locked(lk1), .err_cnt(ec1)
`endif
  );

  prbs_gen_chk #(.W(8), .CNT_W(16)) u_gen8 (
    .clk(clk), .reset(reset), .en(en8), .load(load8), .mode(mode8), .seed(seed8),
    .dout(dout8), .valid(valid8)
`ifdef PRBS_CHECKER_EN
    , .din(dout8), .din_valid(valid8), .err_clr(1'b0), .locked(lk8), .err_cnt(ec8)
`endif
  );

`ifdef PRBS_CHECKER_EN
  prbs_gen_chk #(.W(4), .CNT_W(4)) u_chk4 (
    .clk(clk), .reset(reset), .en(en4), .load(load4), .mode(mode4), .seed(seed4),
    .dout(dout4), .valid(valid4), .din(din4), .din_valid(valid4), .err_clr(err_clr4),
    .locked(locked4), .err_cnt(err_cnt4)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] m_next(input logic [31:0] st, input int m);
    logic b;
    b = st[l_tab[m]-1] ^ st[t_tab[m]-1];
    return ((st << 1) | 32'(b)) & ((32'h1 << l_tab[m]) - 32'h1);
  endfunction

  function automatic logic [31:0] load_state(input logic [30:0] sd, input int m);
    logic [31:0] mk, v;
    mk = (32'h1 << l_tab[m]) - 32'h1;
    v  = {1'b0, sd} & mk;
    return (v == 32'h0) ? mk : v;
  endfunction

  task automatic score();
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("w1_valid", 64'(valid1), 64'(e.v));
      check("w1_dout", 64'(dout1), 64'(e.w[0]));
      if (e.v && valid1) hist.push_back(dout1[0]);
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      check("w8_valid", 64'(valid8), 64'(e.v));
      check("w8_dout", 64'(dout8), 64'(e.w));
    end
  endtask

  task automatic step(input logic e1, input logic l1, input logic [1:0] md1, input logic [30:0] sd1,
                      input logic e8, input logic l8, input logic [1:0] md8, input logic [30:0] sd8);
    exp_t       e;
    logic [7:0] w;
    @(negedge clk);
    score();
    en1 = e1; load1 = l1; mode1 = md1; seed1 = sd1;
    en8 = e8; load8 = l8; mode8 = md8; seed8 = sd8;
    if (l1) begin
      m1_mode = int'(md1);
      m1_st   = load_state(sd1, m1_mode);
      e.v     = 1'b0;
    end else if (e1) begin
      m1_st   = m_next(m1_st, m1_mode);
      w1_last = {7'd0, m1_st[0]};
      e.v     = 1'b1;
    end else begin
      e.v     = 1'b0;
    end
    e.w = w1_last;
    q1.push_back(e);
    if (l8) begin
      m8_mode = int'(md8);
      m8_st   = load_state(sd8, m8_mode);
      e.v     = 1'b0;
    end else if (e8) begin
      w = '0;
      for (int k = 0; k < 8; k++) begin
        m8_st = m_next(m8_st, m8_mode);
        w     = {w[6:0], m8_st[0]};
      end
      w8_last = w;
      e.v     = 1'b1;
    end else begin
      e.v     = 1'b0;
    end
    e.w = w8_last;
    q8.push_back(e);
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 2'd0, 31'd0, 1'b0, 1'b0, 2'd0, 31'd0);
    @(negedge clk);
    score();
  endtask

  task automatic model_reset();
    q1.delete();
    q8.delete();
    m1_st = 32'h7F; m1_mode = 0; w1_last = '0;
    m8_st = 32'h7F; m8_mode = 0; w8_last = '0;
  endtask

  initial begin
    logic [6:0] h;
    reset = 1'b0;
    en1 = 0; load1 = 0; mode1 = 0; seed1 = 0;
    en8 = 0; load8 = 0; mode8 = 0; seed8 = 0;
`ifdef PRBS_CHECKER_EN
    en4 = 0; load4 = 0; mode4 = 0; seed4 = 0; err_clr4 = 0; err_mask = 0;
`endif
    repeat (3) @(negedge clk);
    check("rst_dout1", 64'(dout1), 64'd0);
    check("rst_valid1", 64'(valid1), 64'd0);
    check("rst_dout8", 64'(dout8), 64'd0);
    check("rst_valid8", 64'(valid8), 64'd0);
`ifdef PRBS_CHECKER_EN
    check("rst_locked", 64'(locked4), 64'd0);
    check("rst_errcnt", 64'(err_cnt4), 64'd0);
`endif
    reset = 1'b1;
    model_reset();

    // PRBS7 from reset, one bit per clock: fixed prefix, period 127
    for (int i = 0; i < 140; i++) step(1'b1, 1'b0, 2'd0, 31'd0, 1'b0, 1'b0, 2'd0, 31'd0);
    flush();
    check("hist_len", 64'(hist.size()), 64'd140);
    h = '0;
    for (int i = 0; i < 7; i++) h = {h[5:0], hist[i]};
    check("prbs7_first7", 64'(h), 64'(7'b0000001));
    h = '0;
    for (int i = 127; i < 134; i++) h = {h[5:0], hist[i]};
    check("prbs7_period", 64'(h), 64'(7'b0000001));

    // W=8 PRBS15: en toggled 1,0,1 then continuous
    step(1'b0, 1'b0, 2'd0, 31'd0, 1'b1, 1'b1, 2'd1, 31'h1234);
    step(1'b0, 1'b0, 2'd0, 31'd0, 1'b1, 1'b0, 2'd0, 31'd0);
    step(1'b0, 1'b0, 2'd0, 31'd0, 1'b0, 1'b0, 2'd0, 31'd0);
    step(1'b0, 1'b0, 2'd0, 31'd0, 1'b1, 1'b0, 2'd0, 31'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'd0, 31'd0, 1'b1, 1'b0, 2'd0, 31'd0);
    flush();

    // Zero-seed loads with en high (load wins); PRBS31 on W=1, PRBS15 on W=8, gaps in en
    step(1'b1, 1'b1, 2'd3, 31'd0, 1'b1, 1'b1, 2'd1, 31'h7FFF_8000);
    for (int i = 0; i < 300; i++)
      step((i % 7) != 3, 1'b0, 2'd0, 31'd0, (i % 5) != 2, 1'b0, 2'd0, 31'd0);
    step(1'b0, 1'b1, 2'd2, 31'h00AB_CDEF, 1'b0, 1'b1, 2'd0, 31'h55);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 2'd0, 31'd0, 1'b1, 1'b0, 2'd0, 31'd0);
    flush();

`ifdef PRBS_CHECKER_EN
    // Loopback PRBS23, W=4: lock after 6 hunt words + 4 clean sync words
    @(negedge clk);
    load4 = 1'b1; mode4 = 2'd2; seed4 = 31'h5A5A5; en4 = 1'b1; err_mask = '0;
    @(negedge clk);
    load4 = 1'b0;
    words = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (locked4) begin
        got = 1'b1;
        break;
      end
      if (valid4) words++;
      @(negedge clk);
    end
    check("lock_reached", 64'(got), 64'd1);
    check("lock_words", 64'(words), 64'd10);
    check("lock_errcnt", 64'(err_cnt4), 64'd0);

    err_mask = 4'b0010;
    @(negedge clk);
    err_mask = '0;
    check("one_bit_cnt", 64'(err_cnt4), 64'd1);
    check("one_bit_locked", 64'(locked4), 64'd1);
    @(negedge clk);

    err_mask = 4'b0001; err_clr4 = 1'b1;
    @(negedge clk);
    err_mask = '0; err_clr4 = 1'b0;
    check("clr_wins", 64'(err_cnt4), 64'd0);
    @(negedge clk);

    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      err_mask = sat_masks[i];
      exp_cnt  = exp_cnt + $countones(sat_masks[i]);
      if (exp_cnt > 15) exp_cnt = 15;
      @(negedge clk);
      check("sat_cnt", 64'(err_cnt4), 64'(exp_cnt));
    end
    err_mask = '0;
    check("sat_locked", 64'(locked4), 64'd1);

    for (int i = 0; i < 4; i++) begin
      err_mask = 4'b1000;
      @(negedge clk);
      check("drop_locked", 64'(locked4), (i == 3) ? 64'd0 : 64'd1);
    end
    err_mask = '0;
    check("drop_errcnt", 64'(err_cnt4), 64'd15);
`endif

    // Asynchronous reset in the middle of a running word
    en1 = 1'b1; en8 = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_dout1", 64'(dout1), 64'd0);
    check("mid_rst_valid1", 64'(valid1), 64'd0);
    check("mid_rst_dout8", 64'(dout8), 64'd0);
    check("mid_rst_valid8", 64'(valid8), 64'd0);
`ifdef PRBS_CHECKER_EN
    check("mid_rst_locked", 64'(locked4), 64'd0);
    check("mid_rst_errcnt", 64'(err_cnt4), 64'd0);
    check("mid_rst_valid4", 64'(valid4), 64'd0);
    en4 = 1'b0;
`endif
    en1 = 1'b0; en8 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 2'd0, 31'd0, 1'b1, 1'b0, 2'd0, 31'd0);
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
